memory_access_stage: RTL and testbench

Memory-stage access controller directly downstream of the ExecuteMemory register. It turns scalar and vector load/store requests into a sequence of byte-wide accesses to a synchronous data RAM. Vector operations take multiple cycles, so the block stalls the pipeline until the access completes. Its results feed the MemoryWriteback register.

---
 rtl/memory_access_stage.sv | 153 +++++++++++++++
 tb/tb_memory_access_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// Memory-stage access controller: breaks scalar and vector loads/stores into
// byte-wide accesses to a synchronous data RAM and stalls the pipeline meanwhile.
module memory_access_stage #(
  parameter int ADDR_WIDTH = 16,
  parameter int LANES      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_memory_enable_a_memory,
  input  logic                  write_memory_enable_b_memory,
  input  logic                  load_instruction_memory,
  input  logic                  vector_load_memory,
  input  logic [ADDR_WIDTH-1:0] address_memory,
  input  logic [15:0]           srcB_memory,
  input  logic [8*LANES-1:0]    vector_srcB_memory,
  input  logic [7:0]            mem_read_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_write_data,
  output logic                  mem_write_enable,
  output logic [15:0]           load_data_memory,
  output logic [8*LANES-1:0]    vector_load_data_memory,
  output logic                  stall_memory,
  output logic                  done_memory
);

  localparam int VW = 8 * LANES;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, SLD_WAIT, VST, VLD, VLD_DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [VW-1:0]         vdata_q, vdata_d;
  logic [15:0]           load_q, load_d;
  logic [VW-1:0]         vload_q, vload_d;

  logic                  vst_req, vld_req, sst_req, sld_req;
  logic                  last_lane;
  logic [CW-1:0]         cnt_m1;
  logic [ADDR_WIDTH-1:0] lane_addr;
  logic                  unused_srcb_hi;

  assign unused_srcb_hi = ^srcB_memory[15:8];

  // Fixed priority: vector store > vector load > scalar store > scalar load.
  assign vst_req = write_memory_enable_b_memory;
  assign vld_req = !vst_req && vector_load_memory;
  assign sst_req = !vst_req && !vld_req && write_memory_enable_a_memory;
  assign sld_req = !vst_req && !vld_req && !sst_req && load_instruction_memory;

  assign last_lane = (cnt_q == CW'(LANES - 1));
  assign cnt_m1    = cnt_q - 1'b1;
  assign lane_addr = base_q + ADDR_WIDTH'(cnt_q);

  assign load_data_memory        = load_q;
  assign vector_load_data_memory = vload_q;

  // stall_memory high means the upstream stages must hold this instruction;
  // the cycle after it drops (DONE, or an IDLE scalar store) the upstream may advance.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    base_d           = base_q;
    vdata_d          = vdata_q;
    load_d           = load_q;
    vload_d          = vload_q;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    stall_memory     = 1'b0;
    done_memory      = 1'b0;
    case (state_q)
      IDLE: begin
        if (vst_req) begin
          stall_memory = 1'b1;
          base_d       = address_memory;
          vdata_d      = vector_srcB_memory;
          cnt_d        = '0;
          state_d      = VST;
        end else if (vld_req) begin
          stall_memory = 1'b1;
          base_d       = address_memory;
          cnt_d        = '0;
          state_d      = VLD;
        end else if (sst_req) begin
          mem_address      = address_memory;
          mem_write_data   = srcB_memory[7:0];
          mem_write_enable = 1'b1;
        end else if (sld_req) begin
          mem_address  = address_memory;
          stall_memory = 1'b1;
          state_d      = SLD_WAIT;
        end
      end
      SLD_WAIT: begin
        stall_memory = 1'b1;
        load_d       = {8'h00, mem_read_data};
        state_d      = DONE;
      end
      VST: begin
        mem_address      = lane_addr;
        mem_write_data   = vdata_q[{cnt_q, 3'b000} +: 8];
        mem_write_enable = 1'b1;
        stall_memory     = 1'b1;
        cnt_d            = cnt_q + 1'b1;
        if (last_lane) state_d = DONE;
      end
      VLD: begin
        mem_address  = lane_addr;
        stall_memory = 1'b1;
        // Read data trails the address by one cycle, so lane cnt-1 arrives now.
        if (cnt_q != '0) vload_d[{cnt_m1, 3'b000} +: 8] = mem_read_data;
        cnt_d = cnt_q + 1'b1;
        if (last_lane) state_d = VLD_DRAIN;
      end
      VLD_DRAIN: begin
        stall_memory          = 1'b1;
        vload_d[VW-1 -: 8]    = mem_read_data;
        state_d               = DONE;
      end
      DONE: begin
        done_memory = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      mem_write_enable = 1'b0;
      stall_memory     = 1'b0;
      done_memory      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      vdata_q <= '0;
      load_q  <= '0;
      vload_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      vdata_q <= vdata_d;
      load_q  <= load_d;
      vload_q <= vload_d;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: table of scalar vectors, hand-written
// vector/priority/reset sequences, and a byte-write scoreboard on the RAM port.
module tb_memory_access_stage;

  localparam int AW    = 16;
  localparam int LANES = 16;
  localparam int VW    = 8 * LANES;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_a, wr_b, ld_s, ld_v;
  logic [AW-1:0] address;
  logic [15:0]   srcb;
  logic [VW-1:0] vsrcb;
  logic [7:0]    mem_read_data = '0;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_write_data;
  logic          mem_write_enable;
  logic [15:0]   load_data;
  logic [VW-1:0] vload_data;
  logic          stall, done;

  memory_access_stage #(.ADDR_WIDTH(AW), .LANES(LANES)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .write_memory_enable_a_memory (wr_a),
    .write_memory_enable_b_memory (wr_b),
    .load_instruction_memory      (ld_s),
    .vector_load_memory           (ld_v),
    .address_memory               (address),
    .srcB_memory                  (srcb),
    .vector_srcB_memory           (vsrcb),
    .mem_read_data                (mem_read_data),
    .mem_address                  (mem_address),
    .mem_write_data               (mem_write_data),
    .mem_write_enable             (mem_write_enable),
    .load_data_memory             (load_data),
    .vector_load_data_memory      (vload_data),
    .stall_memory                 (stall),
    .done_memory                  (done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model + write scoreboard ----------------
  logic [7:0]  ram [0:65535];
  logic [AW-1:0] rd_addr = '0;
  logic [23:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) begin
      ram[mem_address] = mem_write_data;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_address, mem_write_data);
      end else begin
        check("write", {mem_address, mem_write_data}, exp_q.pop_front());
      end
    end
    rd_addr = mem_address;
  end

  always @(posedge clk) mem_read_data <= ram[rd_addr];

  // ---------------- driver tasks ----------------
  task automatic clear_req();
    wr_a = 0; wr_b = 0; ld_s = 0; ld_v = 0;
    address = '0; srcb = '0; vsrcb = '0;
  endtask

  // Inputs are already applied; wait for done (bounded), then let DONE retire.
  task automatic run_op(output int lat, output int stalls);
    lat = 0;
    stalls = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    clear_req();
  endtask

  function automatic logic [VW-1:0] ramp(input logic [7:0] start);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*8 +: 8] = start + 8'(i);
    return r;
  endfunction

  task automatic push_writes(input logic [AW-1:0] base, input logic [VW-1:0] data, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({base + AW'(i), data[i*8 +: 8]});
  endtask

  // ---------------- vectors ----------------
  typedef enum logic {OP_SST, OP_SLD} op_e;
  typedef struct {
    op_e         op;
    logic [15:0] addr;
    logic [15:0] srcb;
    logic [7:0]  exp;
  } sc_vec_t;

  sc_vec_t tbl [8];

  initial begin
    int lat, st;
    logic [15:0] last_load;

    tbl[0] = '{OP_SST, 16'h0010, 16'h00A5, 8'h00};
    tbl[1] = '{OP_SLD, 16'h0010, 16'h0000, 8'hA5};
    tbl[2] = '{OP_SST, 16'h0010, 16'h135A, 8'h00};
    tbl[3] = '{OP_SLD, 16'h0010, 16'h0000, 8'h5A};
    tbl[4] = '{OP_SST, 16'hFFF0, 16'hFFC3, 8'h00};
    tbl[5] = '{OP_SLD, 16'hFFF0, 16'h0000, 8'hC3};
    tbl[6] = '{OP_SLD, 16'h0400, 16'h0000, 8'h00};
    tbl[7] = '{OP_SLD, 16'h0433, 16'h0000, 8'h33};

    for (int a = 0; a < 65536; a++) ram[a] = 8'(a);
    reset = 1'b1;
    clear_req();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_we", mem_write_enable, 0);
    check("rst_done", done, 0);
    check("rst_load", load_data, 0);
    check("rst_vload", vload_data, 0);
    check("rst_addr", mem_address, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    last_load = '0;
    for (int i = 0; i < 8; i++) begin
      address = tbl[i].addr;
      if (tbl[i].op == OP_SST) begin
        srcb = tbl[i].srcb;
        wr_a = 1'b1;
        exp_q.push_back({tbl[i].addr, tbl[i].srcb[7:0]});
        @(negedge clk);
        check("sst_we", mem_write_enable, 1);
        check("sst_addr", mem_address, tbl[i].addr);
        check("sst_data", mem_write_data, tbl[i].srcb[7:0]);
        check("sst_stall", stall, 0);
        @(posedge clk); #1;
        clear_req();
      end else begin
        ld_s = 1'b1;
        run_op(lat, st);
        check("sld_latency", lat, 3);
        check("sld_stalls", st, 2);
        check("sld_data", load_data, {8'h00, tbl[i].exp});
        last_load = {8'h00, tbl[i].exp};
      end
    end

    // Vector store, base 0x0020, lane i = i+1
    address = 16'h0020; vsrcb = ramp(8'h01); wr_b = 1'b1;
    push_writes(16'h0020, ramp(8'h01), LANES);
    run_op(lat, st);
    check("vst_latency", lat, 18);
    check("vst_stalls", st, 17);
    check("vst_load_hold", load_data, last_load);

    // Vector load across the address wrap
    address = 16'hFFF8; ld_v = 1'b1;
    run_op(lat, st);
    check("vld_wrap_latency", lat, 19);
    check("vld_wrap_stalls", st, 18);
    check("vld_wrap_data", vload_data, ramp(8'hF8));

    address = 16'h0020; ld_v = 1'b1;
    run_op(lat, st);
    check("vld_readback", vload_data, ramp(8'h01));

    // Vector store whose writes wrap past 0xFFFF
    address = 16'hFFFC; vsrcb = ramp(8'hF0); wr_b = 1'b1;
    push_writes(16'hFFFC, ramp(8'hF0), LANES);
    run_op(lat, st);
    check("vst_wrap_latency", lat, 18);

    // Vector store beats a scalar load
    address = 16'h0040; vsrcb = ramp(8'h80); wr_b = 1'b1; ld_s = 1'b1;
    push_writes(16'h0040, ramp(8'h80), LANES);
    run_op(lat, st);
    check("prio_vst_latency", lat, 18);
    check("prio_vst_load_hold", load_data, last_load);

    // Vector load beats a scalar store (scoreboard flags any write)
    address = 16'h0050; srcb = 16'h00EE; ld_v = 1'b1; wr_a = 1'b1;
    run_op(lat, st);
    check("prio_vld_latency", lat, 19);
    check("prio_vld_data", vload_data, ramp(8'h50));
    check("vld_vload_hold_load", load_data, last_load);

    @(negedge clk);
    check("idle_stall", stall, 0);
    check("idle_done", done, 0);
    check("idle_addr", mem_address, 0);
    check("idle_wdata", mem_write_data, 0);

    // Reset during the sixth VST cycle: exactly five bytes land
    @(posedge clk); #1;
    address = 16'h0060; vsrcb = ramp(8'h30); wr_b = 1'b1;
    push_writes(16'h0060, ramp(8'h30), 5);
    @(negedge clk);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_we", mem_write_enable, 0);
    check("abort_stall", stall, 0);
    check("abort_done", done, 0);
    clear_req();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_load_clr", load_data, 0);
    check("abort_vload_clr", vload_data, 0);
    @(posedge clk); #1;

    address = 16'h0064; ld_s = 1'b1;
    run_op(lat, st);
    check("post_abort_latency", lat, 3);
    check("post_abort_written", load_data, 16'h0034);
    address = 16'h0065; ld_s = 1'b1;
    run_op(lat, st);
    check("post_abort_unwritten", load_data, 16'h0065);

    check("pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
